// File: rtl/plate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plate_pkg
// Description : Geometry and state encodings shared by the plate controller
//               and the plate renderer, so both agree on the drawable range
//               and on the clamp limits of the plate centre.
//               Y_MAX           : top of drawable y range
//               PLATE_HALFWIDTH : plate half-length
//               Y_TOP / Y_BOT   : highest / lowest legal plate centre
//               y_step_up/down  : clamped 9-bit centre arithmetic
// Revision    : 1.0 - initial release
// ============================================================================
package plate_pkg;

  localparam int unsigned Y_MAX           = 220;
  localparam int unsigned PLATE_HALFWIDTH = 15;

  // Centre limits that keep the whole plate inside 0..Y_MAX.
  localparam int unsigned Y_TOP = Y_MAX - PLATE_HALFWIDTH;
  localparam int unsigned Y_BOT = PLATE_HALFWIDTH;

  localparam logic [7:0] Y_TOP_8 = 8'(Y_TOP);
  localparam logic [7:0] Y_BOT_8 = 8'(Y_BOT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } plate_state_e;

  // Move up by step, saturating at Y_TOP. Done in 9 bits so a large
  // centre plus step can never wrap back to a small value.
  function automatic logic [7:0] y_step_up(input logic [7:0] y, input logic [8:0] step);
    logic [8:0] sum;
    sum = {1'b0, y} + step;
    if (sum > {1'b0, Y_TOP_8}) begin
      return Y_TOP_8;
    end
    return sum[7:0];
  endfunction

  // Move down by step, saturating at Y_BOT. The compare is done before
  // the subtraction so the 9-bit result can never underflow.
  function automatic logic [7:0] y_step_down(input logic [7:0] y, input logic [8:0] step);
    logic [8:0] diff;
    if ({1'b0, y} < ({1'b0, Y_BOT_8} + step)) begin
      return Y_BOT_8;
    end
    diff = {1'b0, y} - step;
    return diff[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability counter for one
//               raw, bouncing push-button. The debounced level only flips
//               after the synchronised input has disagreed with it for
//               DEBOUNCE_CYCLES consecutive cycles.
// Ports       : clk    - system clock, rising edge
//               rst    - synchronous active-high reset
//               raw    - asynchronous bouncing button input
//               stable - debounced button level
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/plate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : plate_ctrl
// Description : Turns raw up/down push-buttons into the 8-bit plate centre
//               used by the plate renderer. Buttons are synchronised and
//               debounced, movement is paced by a tick prescaler, and the
//               centre is clamped so the whole plate stays in 0..Y_MAX.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               btn_up    - raw up button (asynchronous, bouncing)
//               btn_down  - raw down button (asynchronous, bouncing)
//               hold      - game pause, freezes the position while high
//               y_p_mid   - registered plate centre
//               at_top    - centre sits at the upper clamp limit
//               at_bottom - centre sits at the lower clamp limit
//               moving    - controller is in the UP or DOWN state
// Options     : PLATE_CTRL_ACCEL_EN - when defined, holding a direction
//               raises the step to 2x and then 4x every ACCEL_TICKS ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module plate_ctrl
  import plate_pkg::*;
#(
  parameter int unsigned Y_INIT          = 110,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MOVE_DIV        = 100000,
  parameter int unsigned STEP            = 1
`ifdef PLATE_CTRL_ACCEL_EN
  ,
  parameter int unsigned ACCEL_TICKS     = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       hold,
  output logic [7:0] y_p_mid,
  output logic       at_top,
  output logic       at_bottom,
  output logic       moving
);

  localparam int unsigned TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [7:0]        Y_INIT_8  = 8'(Y_INIT);
  localparam logic [8:0]        STEP_9    = 9'(STEP);

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic up_db;
  logic down_db;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .stable(up_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .stable(down_db)
  );

  // --------------------------------------------------------------------------
  // Movement tick prescaler
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
  end

  // --------------------------------------------------------------------------
  // Direction FSM
  // --------------------------------------------------------------------------
  plate_state_e state_q;
  plate_state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (up_db && !down_db) begin
          state_d = ST_UP;
        end else if (down_db && !up_db) begin
          state_d = ST_DOWN;
        end
      end
      ST_UP: begin
        if (!up_db || down_db) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (!down_db || up_db) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pause overrides everything; the FSM restarts from IDLE afterwards.
    if (hold) begin
      state_d = ST_IDLE;
    end
  end

  // The move decision uses the current state, so a tick landing in the
  // same cycle the pause rises is still blocked by the hold term.
  logic move_tick;
  assign move_tick = tick && !hold && ((state_q == ST_UP) || (state_q == ST_DOWN));

  // --------------------------------------------------------------------------
  // Step size
  // --------------------------------------------------------------------------
  logic [8:0] step;

`ifdef PLATE_CTRL_ACCEL_EN
  localparam int unsigned ACC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);

  logic [1:0]       level_q;
  logic [1:0]       level_d;
  logic [ACC_W-1:0] acc_cnt_q;
  logic [ACC_W-1:0] acc_cnt_d;

  always_comb begin
    level_d   = level_q;
    acc_cnt_d = acc_cnt_q;
    if (move_tick) begin
      if (acc_cnt_q == ACC_LAST) begin
        acc_cnt_d = '0;
        if (level_q != 2'd2) begin
          level_d = level_q + 2'd1;
        end
      end else begin
        acc_cnt_d = acc_cnt_q + ACC_ONE;
      end
    end
    // Any state change (into IDLE or a direction reversal) or staying
    // idle restarts the acceleration ramp.
    if ((state_d != state_q) || (state_d == ST_IDLE)) begin
      level_d   = 2'd0;
      acc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 2'd0;
      acc_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign step = STEP_9 << level_q;
`else
  assign step = STEP_9;
`endif

  // --------------------------------------------------------------------------
  // Position and flags
  // --------------------------------------------------------------------------
  logic [7:0] y_q;
  logic [7:0] y_d;
  logic       at_top_q;
  logic       at_bottom_q;
  logic       moving_q;

  always_comb begin
    y_d = y_q;
    if (move_tick) begin
      if (state_q == ST_UP) begin
        y_d = y_step_up(y_q, step);
      end else begin
        y_d = y_step_down(y_q, step);
      end
    end
  end

  // Flags are registered from the next-state values so they line up with
  // y_p_mid in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      y_q         <= Y_INIT_8;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      y_q         <= y_d;
      at_top_q    <= (y_d == Y_TOP_8);
      at_bottom_q <= (y_d == Y_BOT_8);
      moving_q    <= (state_d != ST_IDLE);
    end
  end

  assign y_p_mid   = y_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bottom_q;
  assign moving    = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_plate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_plate_ctrl
// Description : Self-checking bench for plate_ctrl with a cycle reference
//               model feeding an expected-output queue, plus directed
//               milestone checks against fixed geometry values.
//               Build with PLATE_CTRL_ACCEL_EN to cover acceleration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plate_ctrl;

  localparam int DEB   = 4;
  localparam int MDIV  = 8;
  localparam int STEPV = 1;
  localparam int ACC_T = 2;
  localparam int YTOP  = 205;
  localparam int YBOT  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] y_p_mid;
  logic       at_top;
  logic       at_bottom;
  logic       moving;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  plate_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MOVE_DIV       (MDIV),
    .STEP           (STEPV)
`ifdef PLATE_CTRL_ACCEL_EN
    ,
    .ACCEL_TICKS    (ACC_T)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .hold     (hold),
    .y_p_mid  (y_p_mid),
    .at_top   (at_top),
    .at_bottom(at_bottom),
    .moving   (moving)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: pushes the expected {y, at_top, at_bottom, moving}
  // after every rising edge.
  // --------------------------------------------------------------------------
  logic [10:0] exp_q[$];

  int m_s1u, m_s2u, m_s1d, m_s2d, m_cu, m_cd, m_u, m_d;
  int m_tick, m_state, m_y, m_lvl, m_acc;
  bit m_top, m_bot, m_mov;

  always @(posedge clk) begin
    int nst;
    int stp;
    bit mv;
    if (rst) begin
      m_s1u = 0; m_s2u = 0; m_s1d = 0; m_s2d = 0;
      m_cu = 0; m_cd = 0; m_u = 0; m_d = 0;
      m_tick = 0; m_state = 0; m_y = 110; m_lvl = 0; m_acc = 0;
      m_top = 0; m_bot = 0; m_mov = 0;
    end else begin
      mv  = (m_tick == MDIV - 1) && !hold && (m_state != 0);
      stp = STEPV << m_lvl;
      if (mv) begin
        if (m_state == 1) m_y = (m_y + stp > YTOP) ? YTOP : m_y + stp;
        else              m_y = (m_y - stp < YBOT) ? YBOT : m_y - stp;
      end
      nst = m_state;
      if (m_state == 0) begin
        if (m_u == 1 && m_d == 0) nst = 1;
        else if (m_d == 1 && m_u == 0) nst = 2;
      end else if (m_state == 1) begin
        if (m_u == 0 || m_d == 1) nst = 0;
      end else begin
        if (m_d == 0 || m_u == 1) nst = 0;
      end
      if (hold) nst = 0;
`ifdef PLATE_CTRL_ACCEL_EN
      if (mv) begin
        m_acc++;
        if (m_acc == ACC_T) begin
          m_acc = 0;
          if (m_lvl < 2) m_lvl++;
        end
      end
      if (nst == 0 || nst != m_state) begin
        m_lvl = 0;
        m_acc = 0;
      end
`endif
      m_state = nst;
      m_mov   = (nst != 0);
      m_top   = (m_y == YTOP);
      m_bot   = (m_y == YBOT);
      m_tick  = (m_tick == MDIV - 1) ? 0 : m_tick + 1;
      if (m_s2u != m_u) begin
        if (m_cu == DEB - 1) begin m_u = 1 - m_u; m_cu = 0; end
        else m_cu++;
      end else m_cu = 0;
      if (m_s2d != m_d) begin
        if (m_cd == DEB - 1) begin m_d = 1 - m_d; m_cd = 0; end
        else m_cd++;
      end else m_cd = 0;
      m_s2u = m_s1u; m_s1u = int'(btn_up);
      m_s2d = m_s1d; m_s1d = int'(btn_down);
    end
    exp_q.push_back({8'(m_y), m_top, m_bot, m_mov});
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", {21'd0, y_p_mid, at_top, at_bottom, moving}, {21'd0, e});
    end
    if (!rst) begin
      chk("range", 32'((y_p_mid >= 8'(YBOT)) && (y_p_mid <= 8'(YTOP))), 32'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the centre to move, then checks its new value.
  task automatic wait_move(input string tag, input int want, input int limit);
    logic [7:0] start;
    bit seen;
    start = y_p_mid;
    seen  = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (y_p_mid !== start) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk(tag, 32'(y_p_mid), 32'(want));
  endtask

  initial begin
    // Reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn_up   = ~btn_up;
      btn_down = btn_up;
    end
    @(negedge clk);
    chk("rst_y", 32'(y_p_mid), 32'd110);
    chk("rst_mov", 32'(moving), 32'd0);
    chk("rst_top", 32'(at_top), 32'd0);
    chk("rst_bot", 32'(at_bottom), 32'd0);
    rst = 1'b0; btn_up = 1'b1; btn_down = 1'b0;
    cyc(6);
    chk("lat_mov0", 32'(moving), 32'd0);
    chk("lat_y", 32'(y_p_mid), 32'd110);
    cyc(1);
    chk("lat_mov1", 32'(moving), 32'd1);

    // Reset mid-move, then glitch pulses shorter than the debounce window
    rst = 1'b1; btn_up = 1'b0;
    cyc(2);
    chk("rst2_y", 32'(y_p_mid), 32'd110);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_up = ((i % 6) < 3);
      @(negedge clk);
    end
    chk("glitch_y", 32'(y_p_mid), 32'd110);
    chk("glitch_mov", 32'(moving), 32'd0);
    btn_up = 1'b1;
    cyc(80);
    chk("hold80_y", 32'(y_p_mid), 32'd119);
    btn_up = 1'b0;
    cyc(10);
    chk("rel_y", 32'(y_p_mid), 32'd120);
    chk("rel_mov", 32'(moving), 32'd0);

    // Top clamp
    btn_up = 1'b1;
    cyc(1000);
    chk("top_y", 32'(y_p_mid), 32'(YTOP));
    chk("top_flag", 32'(at_top), 32'd1);
    chk("top_bot", 32'(at_bottom), 32'd0);
    btn_up = 1'b0; btn_down = 1'b1;
    wait_move("top_dn", YTOP - 1, 40);
    chk("top_dn_flag", 32'(at_top), 32'd0);

    // Bottom clamp
    cyc(2000);
    chk("bot_y", 32'(y_p_mid), 32'(YBOT));
    chk("bot_flag", 32'(at_bottom), 32'd1);
    chk("bot_top", 32'(at_top), 32'd0);
    btn_down = 1'b0;
    cyc(10);

    // Both buttons, then pause
    btn_up = 1'b1; btn_down = 1'b1;
    cyc(40);
    chk("both_y", 32'(y_p_mid), 32'(YBOT));
    chk("both_mov", 32'(moving), 32'd0);
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(10);
    hold = 1'b1; btn_up = 1'b1;
    cyc(40);
    chk("hold_y", 32'(y_p_mid), 32'(YBOT));
    chk("hold_mov", 32'(moving), 32'd0);
    hold = 1'b0;
    wait_move("unhold", YBOT + 1, 30);
    chk("unhold_mov", 32'(moving), 32'd1);
    btn_up = 1'b0;
    cyc(10);

`ifdef PLATE_CTRL_ACCEL_EN
    begin
      int deltas[6];
      int want;
      deltas = '{1, 1, 2, 2, 4, 4};
      rst = 1'b1;
      cyc(2);
      chk("acc_rst_y", 32'(y_p_mid), 32'd110);
      rst = 1'b0; btn_up = 1'b1;
      want = 110;
      for (int k = 0; k < 6; k++) begin
        want = want + deltas[k];
        wait_move($sformatf("acc_%0d", k), want, 40);
      end
      btn_up = 1'b0;
      cyc(8);
      btn_up = 1'b1;
      wait_move("acc_re", want + 1, 40);
      btn_up = 1'b0;
      cyc(10);
    end
`endif

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
